// File: rtl/pico_mips_pkg.sv
// pico_mips_pkg: opcodes, instruction layout, program constants, ROM image.
// Shared by the picoMIPS core and its ALU.
package pico_mips_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_ADDI = 3'b010,
        OP_MULI = 3'b011,
        OP_IN   = 3'b100,
        OP_OUT  = 3'b101,
        OP_WAIT = 3'b110,
        OP_JMP  = 3'b111
    } op_e;

    localparam int OP_W    = 3;
    localparam int REG_W   = 3;
    localparam int IMM_W   = 8;
    localparam int INSTR_W = OP_W + 2 * REG_W + IMM_W;
    localparam int OP_LSB  = 14;
    localparam int RD_LSB  = 11;
    localparam int RS_LSB  = 8;
    localparam int IMM_LSB = 0;
    localparam int NREGS   = 8;

    // Q1.7 coefficients: 0.75, 0.5, -0.5
    localparam logic signed [IMM_W-1:0] K_P075 = 8'sd96;
    localparam logic signed [IMM_W-1:0] K_P050 = 8'sd64;
    localparam logic signed [IMM_W-1:0] K_M050 = -8'sd64;

    localparam logic signed [IMM_W-1:0] OFS_P = 8'sd20;
    localparam logic signed [IMM_W-1:0] OFS_M = -8'sd20;

    typedef struct packed {
        op_e              op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic [IMM_W-1:0] imm;
    } instr_t;

    function automatic instr_t enc(
        input op_e              op,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs,
        input logic [IMM_W-1:0] imm
    );
        instr_t w;
        w.op  = op;
        w.rd  = rd;
        w.rs  = rs;
        w.imm = imm;
        return w;
    endfunction

    // Fixed affine-transform program; unlisted words are NOP.
    function automatic instr_t rom_image(input logic [7:0] addr);
        instr_t w;
        w = enc(OP_NOP, 3'd0, 3'd0, 8'd0);
        case (addr)
            8'd0:  w = enc(OP_WAIT, 3'd0, 3'd0, 8'd1);
            8'd1:  w = enc(OP_IN,   3'd1, 3'd0, 8'd0);
            8'd2:  w = enc(OP_WAIT, 3'd0, 3'd0, 8'd0);
            8'd3:  w = enc(OP_WAIT, 3'd0, 3'd0, 8'd1);
            8'd4:  w = enc(OP_IN,   3'd2, 3'd0, 8'd0);
            8'd5:  w = enc(OP_MULI, 3'd3, 3'd1, K_P075);
            8'd6:  w = enc(OP_MULI, 3'd4, 3'd2, K_P050);
            8'd7:  w = enc(OP_ADD,  3'd3, 3'd4, 8'd0);
            8'd8:  w = enc(OP_ADDI, 3'd3, 3'd0, OFS_P);
            8'd9:  w = enc(OP_MULI, 3'd5, 3'd1, K_M050);
            8'd10: w = enc(OP_MULI, 3'd6, 3'd2, K_P075);
            8'd11: w = enc(OP_ADD,  3'd5, 3'd6, 8'd0);
            8'd12: w = enc(OP_ADDI, 3'd5, 3'd0, OFS_M);
            8'd13: w = enc(OP_WAIT, 3'd0, 3'd0, 8'd0);
            8'd14: w = enc(OP_OUT,  3'd0, 3'd3, 8'd0);
            8'd15: w = enc(OP_WAIT, 3'd0, 3'd0, 8'd1);
            8'd16: w = enc(OP_OUT,  3'd0, 3'd5, 8'd0);
            8'd17: w = enc(OP_WAIT, 3'd0, 3'd0, 8'd0);
            8'd18: w = enc(OP_JMP,  3'd0, 3'd0, 8'd0);
            default: w = enc(OP_NOP, 3'd0, 3'd0, 8'd0);
        endcase
        return w;
    endfunction

endpackage

// File: rtl/pico_mips_if.sv
// pico_mips_if: switch inputs and LED display of the picoMIPS board.
// The core takes the slave side; the board/bench drives the master side.
interface pico_mips_if #(
    parameter int n = 8
);
    logic [9:0]   SW;
    logic [n-1:0] LED;

    modport master (output SW, input LED);
    modport slave  (input SW, output LED);
endinterface

// File: rtl/pico_mips_alu.sv
// pico_mips_alu: combinational ADD / ADDI / MULI / IN pass-through.
// MULI keeps bits [n+6:7] of the signed product (floor of rs*imm/128).
module pico_mips_alu
    import pico_mips_pkg::*;
#(
    parameter int n = 8
) (
    input  op_e              op,
    input  logic [n-1:0]     a,
    input  logic [n-1:0]     b,
    input  logic [IMM_W-1:0] imm,
    input  logic [n-1:0]     sw,
    output logic [n-1:0]     y
);
    localparam int PW = n + IMM_W;

    logic signed [PW-1:0] prod;
    logic [n-1:0]         imm_x;
    logic                 unused_prod_msb;

    assign imm_x = n'($signed(imm));
    assign prod  = $signed(b) * $signed(imm);
    assign unused_prod_msb = prod[PW-1];

    // Result select; a (rd) passes through for non-writing opcodes.
    always_comb begin
        y = a;
        case (op)
            OP_ADD:  y = a + b;
            OP_ADDI: y = a + imm_x;
            OP_MULI: y = prod[PW-2:IMM_W-1];
            OP_IN:   y = sw;
            default: y = a;
        endcase
    end
endmodule

// File: rtl/pico_mips_cpu.sv
// pico_mips_cpu: single-cycle 8-bit picoMIPS core running a fixed ROM program.
// Build option SW9_RESET_EN: SW[9]=0 acts as an extra synchronous reset.
module pico_mips_cpu
    import pico_mips_pkg::*;
#(
    parameter int n          = 8,
    parameter int PROG_DEPTH = 32
) (
    input logic         clk,
    input logic         reset,
    pico_mips_if.slave  io
);
    localparam int PCW = $clog2(PROG_DEPTH);

    logic [PCW-1:0] pc;
    logic [PCW-1:0] pc_next;
    instr_t         ir;
    logic [n-1:0]   regs [NREGS];
    logic [n-1:0]   rd_val;
    logic [n-1:0]   rs_val;
    logic [n-1:0]   alu_y;
    logic [n-1:0]   led_q;
    logic           rst;
    logic           we;
    logic           led_we;
    logic           stall;
    logic           jump;

`ifdef SW9_RESET_EN
    assign rst = reset | ~io.SW[9];
`else
    logic unused_sw9;
    assign unused_sw9 = io.SW[9];
    assign rst = reset;
`endif

    assign ir = rom_image(8'(pc));

    assign rd_val = (ir.rd == '0) ? '0 : regs[ir.rd];
    assign rs_val = (ir.rs == '0) ? '0 : regs[ir.rs];

    pico_mips_alu #(
        .n (n)
    ) u_alu (
        .op  (ir.op),
        .a   (rd_val),
        .b   (rs_val),
        .imm (ir.imm),
        .sw  (io.SW[n-1:0]),
        .y   (alu_y)
    );

    // Decode: register write, LED write, WAIT stall and jump.
    always_comb begin
        we     = 1'b0;
        led_we = 1'b0;
        stall  = 1'b0;
        jump   = 1'b0;
        case (ir.op)
            OP_ADD, OP_ADDI, OP_MULI, OP_IN: we = 1'b1;
            OP_OUT:  led_we = 1'b1;
            OP_WAIT: stall = (io.SW[8] != ir.imm[0]);
            OP_JMP:  jump = 1'b1;
            default: ;
        endcase
    end

    // Next PC: hold on stall, load target on jump, else increment.
    always_comb begin
        pc_next = pc + 1'b1;
        if (stall) begin
            pc_next = pc;
        end else if (jump) begin
            pc_next = ir.imm[PCW-1:0];
        end
    end

    // Architectural state: PC, register file and LED latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= '0;
            led_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            pc <= pc_next;
            if (led_we) begin
                led_q <= rs_val;
            end
            if (we && ir.rd != '0) begin
                regs[ir.rd] <= alu_y;
            end
        end
    end

    assign io.LED = led_q;
endmodule

// File: tb/tb_pico_mips_cpu.sv
// tb_pico_mips_cpu: directed handshake runs of the affine-transform program.
// Expected LED values come from an integer model through a scoreboard queue.
module tb_pico_mips_cpu;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    logic [7:0] exp_q [$];
    logic [7:0] last_y;

    pico_mips_if #(.n(8)) bus ();

    pico_mips_cpu dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int fmul(input int v, input int k);
        int p;
        int q;
        p = v * k;
        q = p / 128;
        if (p < 0 && q * 128 != p) q = q - 1;
        return q;
    endfunction

    task automatic tick(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_sw(input logic s8, input logic [7:0] d);
        bus.SW = {1'b1, s8, d};
    endtask

    task automatic run_point(input int x, input int y, input string tag);
        logic [7:0] x2;
        logic [7:0] y2;
        logic [7:0] e;
        x2 = 8'(fmul(x, 96) + fmul(y, 64) + 20);
        y2 = 8'(fmul(x, -64) + fmul(y, 96) - 20);
        exp_q.push_back(x2);
        exp_q.push_back(y2);
        set_sw(1'b1, 8'(x));
        tick(3);
        set_sw(1'b0, 8'(x));
        tick(3);
        set_sw(1'b1, 8'(y));
        tick(12);
        set_sw(1'b1, 8'($urandom_range(0, 255)));
        tick(1);
        bus.SW[8] = 1'b0;
        tick(11);
        e = exp_q.pop_front();
        check({tag, "_x2"}, 16'(bus.LED), 16'(e));
        bus.SW[8] = 1'b1;
        tick(3);
        e = exp_q.pop_front();
        check({tag, "_y2"}, 16'(bus.LED), 16'(e));
        last_y = y2;
        bus.SW[8] = 1'b0;
        tick(3);
        check({tag, "_hold"}, 16'(bus.LED), 16'(last_y));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        last_y = 8'h00;
        reset  = 1'b1;
        set_sw(1'b0, 8'h00);
        tick(2);
        check("rst_led", 16'(bus.LED), 16'h0000);
        check("rst_pc", 16'(dut.pc), 16'h0000);
        reset = 1'b0;
        tick(5);
        check("stall_pc", 16'(dut.pc), 16'h0000);

        run_point(6, 20, "p6_20");
        run_point(0, 0, "p0_0");
        run_point(127, 127, "p127");

        set_sw(1'b1, 8'd50);
        tick(3);
        set_sw(1'b0, 8'd50);
        tick(3);
        check("mid_pc3", 16'(dut.pc), 16'h0003);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_rst_pc", 16'(dut.pc), 16'h0000);
        check("mid_rst_led", 16'(bus.LED), 16'h0000);
        run_point(6, 20, "rerun");

        set_sw(1'b1, 8'd9);
        tick(3);
        set_sw(1'b0, 8'd9);
        tick(3);
        bus.SW = 10'b0000000000;
        tick(1);
        set_sw(1'b0, 8'd0);
`ifdef SW9_RESET_EN
        check("sw9_pc", 16'(dut.pc), 16'h0000);
        check("sw9_led", 16'(bus.LED), 16'h0000);
`else
        check("sw9_pc", 16'(dut.pc), 16'h0003);
        check("sw9_led", 16'(bus.LED), 16'(last_y));
`endif
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        run_point(-5, 40, "pneg");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
